// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard/flush controller: FSM encoding,
// default register address width and the debug stall-counter width.
package hazard_pkg;

  localparam int REG_AW = 3;
  localparam int SC_W   = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the EX load writes a register that the
// ID instruction actually reads. Register 0 is hardwired and never conflicts.
module load_use_detect #(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_memRead,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit = id_uses_rt && (id_rt == ex_rd);
  assign hazard = ex_memRead && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Hazard controller beside ID: Mealy stall/flush enables for load-use hazards,
// taken branches and jumps, with an FSM stretching multi-cycle windows.
module hazard_flush_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW            = hazard_pkg::REG_AW,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_memRead,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              id_jump,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              ctrl_flush_sel,
  output logic              busy,
  output logic [SC_W-1:0]   stall_count
);

  localparam logic [2:0] STALL_REM = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_REM = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] rem;
  logic [2:0] rem_nxt;
  logic       hazard;
  logic       pc_write_c;
  logic       ifid_write_c;
  logic       ifid_flush_c;
  logic       ctrl_flush_c;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_memRead (ex_memRead),
    .ex_rd      (ex_rd),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    ifid_flush_c = 1'b0;
    ctrl_flush_c = 1'b0;

    // A taken branch wins in every state: whatever sits in ID is wrong-path.
    if (ex_branch_taken) begin
      ifid_flush_c = 1'b1;
      ctrl_flush_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = ST_FLUSH;
        rem_nxt   = FLUSH_REM;
      end else begin
        state_nxt = ST_RUN;
        rem_nxt   = '0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            ctrl_flush_c = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt = ST_STALL;
              rem_nxt   = STALL_REM;
            end
          end else if (id_jump) begin
            ifid_flush_c = 1'b1;
          end
        end
        ST_STALL: begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          ctrl_flush_c = 1'b1;
          rem_nxt      = rem - 3'd1;
          if (rem == 3'd1) state_nxt = ST_RUN;
        end
        ST_FLUSH: begin
          ifid_flush_c = 1'b1;
          ctrl_flush_c = 1'b1;
          rem_nxt      = rem - 3'd1;
          if (rem == 3'd1) state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_RUN;
          rem_nxt   = '0;
        end
      endcase
    end
  end

  // Reset forces a safe frozen pipeline regardless of clock.
  assign pc_write       = rst ? 1'b0 : pc_write_c;
  assign ifid_write     = rst ? 1'b0 : ifid_write_c;
  assign ifid_flush     = rst ? 1'b1 : ifid_flush_c;
  assign ctrl_flush_sel = rst ? 1'b1 : ctrl_flush_c;
  assign busy           = !rst && (state != ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (ctrl_flush_sel && (stall_count != '1)) begin
      stall_count <= stall_count + SC_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench: three hazard_flush_ctrl instances with different window
// lengths share one set of ID/EX inputs; per-cycle expectations are queued.
module tb_hazard_flush_ctrl;

  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_uses_rs;
  logic          id_uses_rt;
  logic          ex_memRead;
  logic [AW-1:0] ex_rd;
  logic          ex_branch_taken;
  logic          id_jump;

  logic        pw [3];
  logic        iw [3];
  logic        ifl[3];
  logic        cf [3];
  logic        bz [3];
  logic [15:0] sc [3];

  hazard_flush_ctrl #(.REG_AW(AW), .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .pc_write(pw[0]),
    .ifid_write(iw[0]), .ifid_flush(ifl[0]), .ctrl_flush_sel(cf[0]), .busy(bz[0]),
    .stall_count(sc[0]));

  hazard_flush_ctrl #(.REG_AW(AW), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .pc_write(pw[1]),
    .ifid_write(iw[1]), .ifid_flush(ifl[1]), .ctrl_flush_sel(cf[1]), .busy(bz[1]),
    .stall_count(sc[1]));

  hazard_flush_ctrl #(.REG_AW(AW), .LOAD_STALL_CYCLES(4), .FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .pc_write(pw[2]),
    .ifid_write(iw[2]), .ifid_flush(ifl[2]), .ctrl_flush_sel(cf[2]), .busy(bz[2]),
    .stall_count(sc[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // en = {pc_write, ifid_write, ifid_flush, ctrl_flush_sel}
  localparam logic [3:0] E_RUN = 4'b1100;
  localparam logic [3:0] E_STL = 4'b0001;
  localparam logic [3:0] E_BR  = 4'b1111;
  localparam logic [3:0] E_JMP = 4'b1110;
  localparam logic [3:0] E_RST = 4'b0011;

  typedef struct {
    string      tag;
    int         d;
    logic [3:0] en;
    logic       busy;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   exp_sc[3];
  int   n_tests;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int d, input logic [3:0] en, input logic b);
    exp_t e;
    e.tag  = tag;
    e.d    = d;
    e.en   = en;
    e.busy = b;
    e.cnt  = exp_sc[d];
    exp_q.push_back(e);
    if (!rst && en[0] && exp_sc[d] < 32'hFFFF) exp_sc[d]++;
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s.d%0d.en", e.tag, e.d),
            32'({pw[e.d], iw[e.d], ifl[e.d], cf[e.d]}), 32'(e.en));
      check($sformatf("%s.d%0d.busy", e.tag, e.d), 32'(bz[e.d]), 32'(e.busy));
      check($sformatf("%s.d%0d.cnt", e.tag, e.d), 32'(sc[e.d]), 32'(e.cnt));
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] e0, input logic b0,
                     input logic [3:0] e1, input logic b1,
                     input logic [3:0] e2, input logic b2);
    push(tag, 0, e0, b0);
    push(tag, 1, e1, b1);
    push(tag, 2, e2, b2);
    @(negedge clk);
    drain();
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_memRead = 1'b0; ex_rd = '0; ex_branch_taken = 1'b0; id_jump = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic set_lu();
    ex_memRead = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 3; i++) exp_sc[i] = 0;
    rst = 1'b1;
    clr();

    next(); cyc("rst0", E_RST, 0, E_RST, 0, E_RST, 0);
    next(); cyc("rst1", E_RST, 0, E_RST, 0, E_RST, 0);
    next(); rst = 1'b0;
    cyc("idle", E_RUN, 0, E_RUN, 0, E_RUN, 0);

    // load-use on rs; 3- and 4-cycle windows stretch via STALL
    next(); set_lu();
    cyc("lu", E_STL, 0, E_STL, 0, E_STL, 0);
    next(); cyc("lu+1", E_RUN, 0, E_STL, 1, E_STL, 1);
    next(); cyc("lu+2", E_RUN, 0, E_STL, 1, E_STL, 1);
    next(); cyc("lu+3", E_RUN, 0, E_RUN, 0, E_STL, 1);
    next(); cyc("lu+4", E_RUN, 0, E_RUN, 0, E_RUN, 0);

    next(); ex_memRead = 1'b1; ex_rd = 3'd0; id_rs = 3'd0; id_uses_rs = 1'b1;
    cyc("r0", E_RUN, 0, E_RUN, 0, E_RUN, 0);
    next(); ex_memRead = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; id_rs = 3'd2; id_uses_rs = 1'b1;
    cyc("rt_unused", E_RUN, 0, E_RUN, 0, E_RUN, 0);
    next(); ex_memRead = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; id_uses_rt = 1'b1;
    cyc("lu_rt", E_STL, 0, E_STL, 0, E_STL, 0);

    // branch lands while dut1/dut2 are stalling
    next(); ex_branch_taken = 1'b1;
    cyc("br_in_stall", E_BR, 0, E_BR, 1, E_BR, 1);
    next(); cyc("br_in_stall+1", E_RUN, 0, E_BR, 1, E_BR, 1);
    next(); cyc("br_in_stall+2", E_RUN, 0, E_RUN, 0, E_RUN, 0);

    next(); ex_branch_taken = 1'b1; set_lu();
    cyc("br_prio", E_BR, 0, E_BR, 0, E_BR, 0);
    next(); cyc("br_prio+1", E_RUN, 0, E_BR, 1, E_BR, 1);
    next(); cyc("br_prio+2", E_RUN, 0, E_RUN, 0, E_RUN, 0);

    next(); id_jump = 1'b1;
    cyc("jump", E_JMP, 0, E_JMP, 0, E_JMP, 0);
    next(); cyc("jump+1", E_RUN, 0, E_RUN, 0, E_RUN, 0);

    next(); ex_branch_taken = 1'b1;
    cyc("br2", E_BR, 0, E_BR, 0, E_BR, 0);
    next(); ex_branch_taken = 1'b1;
    cyc("br2_reload", E_BR, 0, E_BR, 1, E_BR, 1);
    next(); cyc("br2+1", E_RUN, 0, E_BR, 1, E_BR, 1);
    next(); cyc("br2+2", E_RUN, 0, E_RUN, 0, E_RUN, 0);

    // asynchronous reset in the middle of a FLUSH window
    next(); ex_branch_taken = 1'b1;
    cyc("br3", E_BR, 0, E_BR, 0, E_BR, 0);
    next(); cyc("br3+1", E_RUN, 0, E_BR, 1, E_BR, 1);
    #1; rst = 1'b1;
    for (int i = 0; i < 3; i++) exp_sc[i] = 0;
    push("arst", 0, E_RST, 0);
    push("arst", 1, E_RST, 0);
    push("arst", 2, E_RST, 0);
    #1; drain();
    next(); rst = 1'b0;
    cyc("post_rst", E_RUN, 0, E_RUN, 0, E_RUN, 0);

    // hold a hazard long enough to saturate the counter
    next(); set_lu();
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat_pre", 32'(sc[0]), 32'hFFFE);
    check("sat_pre_cf", 32'(cf[0]), 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sat0", 32'(sc[0]), 32'hFFFF);
    check("sat1", 32'(sc[1]), 32'hFFFF);
    check("sat2", 32'(sc[2]), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
